decimator_sequencer: RTL and testbench

DECIMATOR_SEQUENCER -- requirements
Module: decimator_sequencer

---
 rtl/decimator_sequencer.sv | 120 ++++++++++++
 tb/tb_decimator_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/decimator_sequencer.sv
// Control sequencer for a FIR decimator: loads coefficients, flushes the tap
// line with zeros, then gates tap shifts and output loads at the decimation ratio.
module decimator_sequencer #(
    parameter int NUM_TAPS    = 5,
    parameter int COEFF_WIDTH = 7,
    parameter int RATIO_WIDTH = 8,
    localparam int AW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
    input  logic                   src_clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic [RATIO_WIDTH-1:0] cfg_ratio,
    input  logic                   cfg_stop,
    input  logic                   coeff_in_valid,
    output logic                   coeff_in_ready,
    input  logic [COEFF_WIDTH-1:0] coeff_in_data,
    output logic                   coeff_we,
    output logic [AW-1:0]          coeff_addr,
    output logic [COEFF_WIDTH-1:0] coeff_data,
    input  logic                   sample_valid,
    output logic                   tap_en,
    output logic                   x_zero,
    output logic                   y_load,
    output logic [1:0]             state,
    output logic                   overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_e;

    localparam logic [RATIO_WIDTH-1:0] RATIO_ONE  = RATIO_WIDTH'(1);
    localparam logic [AW-1:0]          LAST_ADDR  = AW'(NUM_TAPS - 1);
    localparam logic [AW-1:0]          LAST_FLUSH = AW'((NUM_TAPS > 1) ? NUM_TAPS - 2 : 0);
    localparam state_e                 AFTER_LOAD = (NUM_TAPS > 1) ? FLUSH : RUN;

    state_e                 state_q;
    logic [RATIO_WIDTH-1:0] ratio_q;
    logic [RATIO_WIDTH-1:0] phase_q;
    logic [AW-1:0]          wcnt_q;
    logic [AW-1:0]          flush_q;
    logic                   overrun_q;
    logic                   coeff_we_q;
    logic [AW-1:0]          coeff_addr_q;
    logic [COEFF_WIDTH-1:0] coeff_data_q;
    logic                   phase_wrap;

    assign phase_wrap = (phase_q == (ratio_q - RATIO_ONE));

    always_ff @(posedge src_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ratio_q      <= RATIO_ONE;
            phase_q      <= '0;
            wcnt_q       <= '0;
            flush_q      <= '0;
            overrun_q    <= 1'b0;
            coeff_we_q   <= 1'b0;
            coeff_addr_q <= '0;
            coeff_data_q <= '0;
        end else begin
            coeff_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        state_q   <= LOAD;
                        ratio_q   <= (cfg_ratio == '0) ? RATIO_ONE : cfg_ratio;
                        overrun_q <= 1'b0;
                        wcnt_q    <= '0;
                        phase_q   <= '0;
                    end
                end
                LOAD: begin
                    if (sample_valid) overrun_q <= 1'b1;
                    if (coeff_in_valid) begin
                        coeff_we_q   <= 1'b1;
                        coeff_addr_q <= wcnt_q;
                        coeff_data_q <= coeff_in_data;
                        wcnt_q       <= wcnt_q + AW'(1);
                        if (wcnt_q == LAST_ADDR) begin
                            wcnt_q  <= '0;
                            flush_q <= '0;
                            phase_q <= '0;
                            state_q <= AFTER_LOAD;
                        end
                    end
                end
                FLUSH: begin
                    if (sample_valid) overrun_q <= 1'b1;
                    if (flush_q == LAST_FLUSH) begin
                        state_q <= RUN;
                        phase_q <= '0;
                    end else begin
                        flush_q <= flush_q + AW'(1);
                    end
                end
                RUN: begin
                    // A stop coinciding with a sample still lets that sample be counted
                    if (sample_valid) phase_q <= phase_wrap ? '0 : phase_q + RATIO_ONE;
                    if (cfg_stop) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign coeff_in_ready = (state_q == LOAD);
    assign tap_en         = (state_q == FLUSH) || ((state_q == RUN) && sample_valid);
    assign x_zero         = (state_q == FLUSH);
    assign y_load         = (state_q == RUN) && sample_valid && phase_wrap;
    assign coeff_we       = coeff_we_q;
    assign coeff_addr     = coeff_addr_q;
    assign coeff_data     = coeff_data_q;
    assign state          = state_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_decimator_sequencer.sv
// Bench for decimator_sequencer: directed scenarios plus random traffic, each
// cycle compared against a sample-counting reference model.
module tb_decimator_sequencer;

    localparam int NT = 5;
    localparam int CW = 7;
    localparam int RW = 8;
    localparam int AW = 3;

    logic          src_clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_start = 1'b0;
    logic [RW-1:0] cfg_ratio = '0;
    logic          cfg_stop = 1'b0;
    logic          coeff_in_valid = 1'b0;
    logic          coeff_in_ready;
    logic [CW-1:0] coeff_in_data = '0;
    logic          coeff_we;
    logic [AW-1:0] coeff_addr;
    logic [CW-1:0] coeff_data;
    logic          sample_valid = 1'b0;
    logic          tap_en;
    logic          x_zero;
    logic          y_load;
    logic [1:0]    state;
    logic          overrun;

    int total = 0;
    int bad = 0;

    // Reference model: mode 0..3 follows the state port encoding
    int m_mode = 0;
    int m_ratio = 1;
    int m_samples = 0;
    int m_words = 0;
    int m_flushLeft = 0;
    int m_over = 0;
    int m_we = 0;
    int m_addr = 0;
    int m_data = 0;
    int m_fresh = 1;
    int yCount = 0;

    decimator_sequencer #(.NUM_TAPS(NT), .COEFF_WIDTH(CW), .RATIO_WIDTH(RW)) dut (
        .src_clk(src_clk), .rst(rst), .cfg_start(cfg_start), .cfg_ratio(cfg_ratio),
        .cfg_stop(cfg_stop), .coeff_in_valid(coeff_in_valid), .coeff_in_ready(coeff_in_ready),
        .coeff_in_data(coeff_in_data), .coeff_we(coeff_we), .coeff_addr(coeff_addr),
        .coeff_data(coeff_data), .sample_valid(sample_valid), .tap_en(tap_en),
        .x_zero(x_zero), .y_load(y_load), .state(state), .overrun(overrun)
    );

    always #5 src_clk = ~src_clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, checks outputs before the edge, then advances the model
    task automatic applyStimulus(input bit iStart, input int iRatio, input bit iStop,
                                 input bit iValid, input int iData, input bit iSv, input bit iRst);
        int expTap, expZero, expY, expReady;
        @(negedge src_clk);
        cfg_start      = iStart;
        cfg_ratio      = RW'(iRatio);
        cfg_stop       = iStop;
        coeff_in_valid = iValid;
        coeff_in_data  = CW'(iData);
        sample_valid   = iSv;
        rst            = iRst;
        #1;
        expReady = (m_mode == 1);
        expZero  = (m_mode == 2);
        expTap   = (m_mode == 2) || (m_mode == 3 && iSv);
        expY     = (m_mode == 3 && iSv && ((m_samples + 1) % m_ratio == 0));
        checkOutput("state", int'(state), m_mode);
        checkOutput("coeff_in_ready", int'(coeff_in_ready), expReady);
        checkOutput("tap_en", int'(tap_en), expTap);
        checkOutput("x_zero", int'(x_zero), expZero);
        checkOutput("y_load", int'(y_load), expY);
        checkOutput("overrun", int'(overrun), m_over);
        checkOutput("coeff_we", int'(coeff_we), m_we);
        if (m_we == 1 || m_fresh == 1) begin
            checkOutput("coeff_addr", int'(coeff_addr), m_addr);
            checkOutput("coeff_data", int'(coeff_data), m_data);
        end
        if (expY == 1) yCount++;
        @(posedge src_clk);
        if (iRst) begin
            m_mode = 0; m_ratio = 1; m_samples = 0; m_words = 0; m_over = 0;
            m_we = 0; m_addr = 0; m_data = 0; m_fresh = 1;
        end else begin
            m_we = 0;
            case (m_mode)
                0: if (iStart) begin
                    m_mode = 1;
                    m_ratio = (iRatio % 256 == 0) ? 1 : iRatio % 256;
                    m_over = 0;
                    m_words = 0;
                end
                1: begin
                    if (iSv) m_over = 1;
                    if (iValid) begin
                        m_we = 1; m_fresh = 0;
                        m_addr = m_words;
                        m_data = iData % 128;
                        m_words++;
                        if (m_words == NT) begin
                            m_mode = 2;
                            m_flushLeft = NT - 1;
                        end
                    end
                end
                2: begin
                    if (iSv) m_over = 1;
                    m_flushLeft--;
                    if (m_flushLeft == 0) begin
                        m_mode = 3;
                        m_samples = 0;
                    end
                end
                default: begin
                    if (iSv) m_samples++;
                    if (iStop) m_mode = 0;
                end
            endcase
        end
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic runUntilMode(input int target, input int budget);
        int n = 0;
        while (m_mode != target && n < budget) begin
            idleCycle();
            n++;
        end
        total++;
        if (m_mode != target) begin
            bad++;
            $display("[TB] FAIL wait_mode observed=%0d expected=%0d", m_mode, target);
        end
    endtask

    task automatic sampleWithGap(input bit withStop);
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) idleCycle();
        applyStimulus(0, 0, withStop, 0, 0, 1, 0);
    endtask

    initial begin
        int yBefore;
        int k;

        // Reset state
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        idleCycle();

        // Ratio 4: back-to-back coefficients 1..5, flush, then 12 gapped samples
        applyStimulus(1, 4, 0, 0, 0, 0, 0);
        for (int i = 0; i < NT; i++) applyStimulus(0, 0, 0, 1, i + 1, 0, 0);
        for (int i = 0; i < NT - 1; i++) idleCycle();
        checkOutput("mode_after_flush", m_mode, 3);
        yBefore = yCount;
        for (int i = 0; i < 12; i++) sampleWithGap(0);
        checkOutput("yload_count_ratio4", yCount - yBefore, 3);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        idleCycle();

        // Ratio 0 treated as 1; toggling valid; ignored stop in LOAD; overrun in FLUSH
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        k = 0;
        while (m_mode == 1 && k < 20) begin
            applyStimulus(0, 0, 0, (k % 2 == 0), $urandom_range(0, 127), 0, 0);
            k++;
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        runUntilMode(3, 10);
        applyStimulus(1, 7, 0, 0, 0, 0, 0);
        yBefore = yCount;
        for (int i = 0; i < 3; i++) sampleWithGap(0);
        checkOutput("yload_count_ratio1", yCount - yBefore, 3);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);

        // Stop coincident with the ratio-th sample
        applyStimulus(1, 3, 0, 0, 0, 0, 0);
        for (int i = 0; i < NT; i++) applyStimulus(0, 0, 0, 1, $urandom_range(0, 127), 0, 0);
        runUntilMode(3, 10);
        sampleWithGap(0);
        sampleWithGap(0);
        sampleWithGap(1);
        idleCycle();

        // Reset after two coefficient writes
        applyStimulus(1, 5, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 9, 0, 0);
        applyStimulus(0, 0, 0, 1, 10, 1, 0);
        applyStimulus(0, 0, 0, 1, 11, 0, 1);
        idleCycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 9) == 0), $urandom_range(0, 5),
                          ($urandom_range(0, 24) == 0), ($urandom_range(0, 1) == 1),
                          $urandom_range(0, 127), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 59) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
